booth_mult_r4: RTL and testbench
================================

Name: booth_mult_r4

Overview:
Sequential radix-4 Booth multiplier and parametrised successor of the 64-bit radix-2 multiplier. It supports configurable operand width and a per-operation signed/unsigned mode. It retires two multiplier bits per cycle, so it needs about half the iterations of its predecessor. It keeps the op_start / op_clear / op_done handshake, so it sits in the datapath as a drop-in replacement behind the same controller.

Parameters:
WIDTH, 64, operand width in bits. Must be even and >= 4; elaboration fails otherwise.
ITER, WIDTH/2+1, derived localparam and not overridable. It is the number of radix-4 digits over the (WIDTH+2)-bit extended multiplier.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
multiplicand  input  WIDTH  operand A, sampled on accepted op_start
multiplier  input  WIDTH  operand B, sampled on accepted op_start
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands
op_start  input  1  start request, level-sampled
op_clear  input  1  synchronous abort/clear, highest priority
busy  output  1  high while in EXEC
op_done  output  1  high while in DONE (result valid)
result  output  2*WIDTH  product; stable while op_done is high

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE
  - result=0, op_done=0, busy=0
  - internal accumulator, operand and counter registers all 0
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> EXEC when op_start=1.
  - EXEC -> DONE after ITER cycles in EXEC.
  - DONE -> EXEC when op_start=1 (back-to-back operation); otherwise DONE holds.
  - Any state -> IDLE when op_clear=1.
- Priority per edge: op_clear > op_start. If both are high, the block goes to IDLE and the operation is not started.
- op_start in EXEC is ignored: no restart and no queuing.
- Operand capture on an accepted start:
  - A is extended to WIDTH+2 bits: sign-extended if signed_mode, else zero-extended.
  - B is extended the same way, and an implicit 0 is appended below its LSB.
  - count=0 and the accumulator is cleared.
  - signed_mode changes after capture have no effect.
- Each EXEC cycle:
  - Recode the triplet {B[2i+1], B[2i], B[2i-1]} into a digit in {-2,-1,0,+1,+2}.
  - The partial product is digit*A, sign-extended to 2*WIDTH+4 bits and shifted left by 2i.
  - Add the partial product into the accumulator; count increments.
  - Arithmetic is modulo 2^(2*WIDTH+4). result is the low 2*WIDTH bits.
- Latency: an op_start accepted at edge 0 gives op_done=1 and a valid result after edge ITER. That is ITER cycles; 33 for WIDTH=64.
- result updates only on entry to DONE and holds until the next accepted start or clear. It does not show partial sums.
- op_done drops on the edge that accepts a new start or a clear.
- Boundary results (both modes exact, no overflow possible in 2*WIDTH bits):
  - Signed: most-negative x most-negative = +2^(2*WIDTH-2).
  - Unsigned: all-ones x all-ones = (2^WIDTH-1)^2.
  - Zero operands give result=0 at the normal latency; there is no early termination.
- op_clear mid-EXEC: the operation is abandoned. Next edge: IDLE, result=0, op_done=0, busy=0.
- reset_n asserted mid-operation clears everything immediately, with no dependency on clk.

Decomposition:
- Package booth_pkg:
  - FSM state enum (IDLE=2'b00, EXEC=2'b01, DONE=2'b10)
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2)
  - function for the ITER computation
- Sub-module booth_r4_enc (combinational): 3-bit triplet -> digit plus one/two/neg controls. It is instantiated once in the top block.
- Top block contains: FSM, operand/accumulator registers, partial-product mux and adder (an inferred adder, or the existing cla128 when WIDTH=64).

Test Plan:
1. Default WIDTH=64, signed: reset, then op_start with A=3, B=-5 -> op_done rises exactly 33 cycles later; result = 128'hFFFF...FFF1 (-15); busy high for those 33 cycles.
2. WIDTH=64, unsigned, A=B=64'hFFFF_FFFF_FFFF_FFFF -> result = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Repeat signed with the same bits -> result = 1.
3. WIDTH=8, signed, A=B=8'h80 -> result = 16'h4000 after 5 cycles. Unsigned, same operands -> 16'h4000. Unsigned A=8'hFF, B=8'h02 -> 16'h01FE.
4. WIDTH=8: op_clear asserted at EXEC cycle 2 -> IDLE next edge, result=0, op_done=0. A later start with A=7, B=6 -> result=42. op_start and op_clear high together in IDLE -> stays IDLE.
5. WIDTH=8: op_start re-pulsed during EXEC -> ignored, latency unchanged. Start held high in DONE -> new operation accepted, op_done drops for exactly 5 cycles.
6. Randomised WIDTH=16 and WIDTH=64: 10k operations, random signed_mode, reset_n pulsed asynchronously mid-EXEC in 1% of runs -> results match the reference model; after any reset pulse, outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
// Provides the FSM state encoding, the Booth digit encoding and the
// iteration-count helper used to size the sequencer.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  // One radix-4 digit per bit pair of the (width+2)-bit extended multiplier.
  function automatic int booth_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth recoder for one multiplier triplet
// Ports:
//   triplet : {b[2i+1], b[2i], b[2i-1]}
//   digit   : recoded digit in {-2,-1,0,+1,+2}
//   one     : select 1x multiplicand
//   two     : select 2x multiplicand
//   neg     : negate the selected multiple
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output digit_e     digit,
  output logic       one,
  output logic       two,
  output logic       neg
);

  always_comb begin
    digit = ZERO;
    one   = 1'b0;
    two   = 1'b0;
    neg   = 1'b0;
    case (triplet)
      3'b001, 3'b010: begin digit = POS1; one = 1'b1; end
      3'b011:         begin digit = POS2; two = 1'b1; end
      3'b100:         begin digit = NEG2; two = 1'b1; neg = 1'b1; end
      3'b101, 3'b110: begin digit = NEG1; one = 1'b1; neg = 1'b1; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// rtl/booth_mult_r4.sv - sequential radix-4 Booth multiplier, signed/unsigned
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   multiplicand, multiplier  : operands A and B, captured on accepted start
//   signed_mode               : 1 = two's complement, 0 = unsigned
//   op_start, op_clear        : start request, synchronous abort (wins)
//   busy, op_done, result     : executing, result valid, 2*WIDTH product
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int ITER = booth_iter(WIDTH);
  localparam int AW   = 2 * WIDTH + 4;
  localparam int BW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_r4: WIDTH must be even and >= 4");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [AW-1:0]        m_q, m_d;
  logic [BW-1:0]        b_q, b_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  digit_e               enc_digit;
  logic                 enc_one, enc_two, enc_neg;
  logic [AW-1:0]        pp_mag, pp, acc_sum;
  logic                 sa, sb;

  // m_q holds A pre-shifted by 2i and b_q holds B shifted right by 2i, so the
  // current digit always comes from b_q[2:0] and no variable shifter is needed.
  booth_r4_enc u_enc (
    .triplet (b_q[2:0]),
    .digit   (enc_digit),
    .one     (enc_one),
    .two     (enc_two),
    .neg     (enc_neg)
  );

  always_comb begin
    pp_mag  = ({AW{enc_one}} & m_q) | ({AW{enc_two}} & {m_q[AW-2:0], 1'b0});
    pp      = enc_neg ? (~pp_mag + AW'(1)) : pp_mag;
    acc_sum = (enc_digit == ZERO) ? acc_q : (acc_q + pp);
  end

  assign sa = signed_mode & multiplicand[WIDTH-1];
  assign sb = signed_mode & multiplier[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = IDLE;
      m_d      = '0;
      b_d      = '0;
      acc_d    = '0;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (op_start) begin
            state_d = EXEC;
            m_d     = {{(AW - WIDTH){sa}}, multiplicand};
            b_d     = {{2{sb}}, multiplier, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        EXEC: begin
          acc_d = acc_sum;
          m_d   = {m_q[AW-3:0], 2'b00};
          b_d   = {2'b00, b_q[BW-1:2]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d  = DONE;
            result_d = acc_sum[2*WIDTH-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q == EXEC);
  assign op_done = (state_q == DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// tb/tb_booth_mult_r4.sv - scoreboard bench for booth_mult_r4 at WIDTH=64 and WIDTH=8
module tb_booth_mult_r4;

  localparam int ITER64 = 33;
  localparam int ITER8  = 5;

  typedef struct {
    logic [127:0] res;
    int           st;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic [63:0]  a64, b64;
  logic         sm64, start64, clear64, busy64, done64;
  logic [127:0] result64;
  logic [7:0]   a8, b8;
  logic         sm8, start8, clear8, busy8, done8;
  logic [15:0]  result8;

  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t q64[$];
  exp_t q8[$];

  booth_mult_r4 #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .multiplicand(a64), .multiplier(b64),
    .signed_mode(sm64), .op_start(start64), .op_clear(clear64),
    .busy(busy64), .op_done(done64), .result(result64)
  );

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .multiplicand(a8), .multiplier(b8),
    .signed_mode(sm8), .op_start(start8), .op_clear(clear8),
    .busy(busy8), .op_done(done8), .result(result8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: one per instance, pop on each rising op_done.
  logic prev64, prev8;
  int   bcnt64, bcnt8;
  initial begin prev64 = 0; prev8 = 0; bcnt64 = 0; bcnt8 = 0; end

  always begin
    @(posedge clk);
    #1;
    if (done64 && !prev64) begin
      if (q64.size() == 0) begin
        check("unexpected_done64", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = q64.pop_front();
        check("result64", result64, e.res);
        check("latency64", 128'(cyc - e.st), 128'(ITER64));
        check("busy_cycles64", 128'(bcnt64), 128'(ITER64));
      end
    end
    if (busy64) bcnt64++;
    else if (!done64) bcnt64 = 0;
    if (done64 && !prev64) bcnt64 = 0;
    prev64 = done64;

    if (done8 && !prev8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("result8", 128'(result8), e.res);
        check("latency8", 128'(cyc - e.st), 128'(ITER8));
        check("busy_cycles8", 128'(bcnt8), 128'(ITER8));
      end
    end
    if (busy8) bcnt8++;
    else if (!done8) bcnt8 = 0;
    if (done8 && !prev8) bcnt8 = 0;
    prev8 = done8;
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q64.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 128'(q64.size() + q8.size()), 128'(0));
    q64.delete();
    q8.delete();
  endtask

  // Operands and mode are scrambled right after the start to show they were captured.
  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic sm, input logic [127:0] exp);
    @(negedge clk);
    a64 = a; b64 = b; sm64 = sm; start64 = 1'b1;
    q64.push_back('{res: exp, st: cyc + 1});
    @(negedge clk);
    start64 = 1'b0; a64 = ~a; b64 = b ^ 64'h5; sm64 = ~sm;
    wait_drain();
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [15:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    q8.push_back('{res: 128'(exp), st: cyc + 1});
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = b ^ 8'h5; sm8 = ~sm;
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0;
    a64 = '0; b64 = '0; sm64 = 0; start64 = 0; clear64 = 0;
    a8 = '0; b8 = '0; sm8 = 0; start8 = 0; clear8 = 0;
    repeat (3) @(negedge clk);
    check("reset_result64", result64, 128'(0));
    check("reset_busy64", 128'(busy64), 128'(0));
    check("reset_done64", 128'(done64), 128'(0));
    check("reset_result8", 128'(result8), 128'(0));
    check("reset_done8", 128'(done8), 128'(0));
    reset_n = 1'b1;

    // WIDTH=64 directed vectors
    op64(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1);
    op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    op64(64'd0, 64'd12345, 1'b1, 128'd0);
    op64(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 1'b0, 128'h0000_0000_0000_0001_0000_0002_0000_0001);
    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9);

    // WIDTH=8 directed vectors and boundaries
    op8(8'h80, 8'h80, 1'b1, 16'h4000);
    op8(8'h80, 8'h80, 1'b0, 16'h4000);
    op8(8'hFF, 8'h02, 1'b0, 16'h01FE);
    op8(8'hFF, 8'h02, 1'b1, 16'hFFFE);
    op8(8'h7F, 8'h80, 1'b1, 16'hC080);
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);

    // Abort mid-EXEC: result from previous op must be wiped
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h09; sm8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    clear8 = 1'b1;
    @(posedge clk); #1;
    check("clear_result8", 128'(result8), 128'(0));
    check("clear_busy8", 128'(busy8), 128'(0));
    check("clear_done8", 128'(done8), 128'(0));
    @(negedge clk);
    clear8 = 1'b0;

    op8(8'h07, 8'h06, 1'b0, 16'h002A);

    // start and clear together: clear wins, from DONE and again from IDLE
    @(negedge clk);
    start8 = 1'b1; clear8 = 1'b1;
    @(posedge clk); #1;
    check("startclr_done8", 128'(done8), 128'(0));
    check("startclr_result8", 128'(result8), 128'(0));
    @(posedge clk); #1;
    check("startclr_busy8", 128'(busy8), 128'(0));
    @(negedge clk);
    start8 = 1'b0; clear8 = 1'b0;
    @(posedge clk); #1;
    check("idle_hold_busy8", 128'(busy8), 128'(0));

    // op_start re-pulsed during EXEC with different operands: ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h0B; sm8 = 0; start8 = 1'b1;
    q8.push_back('{res: 128'(16'h0037), st: cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h13; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_drain();

    // start held high through DONE: back-to-back, op_done low for ITER cycles
    @(negedge clk);
    a8 = 8'h03; b8 = 8'hFD; sm8 = 1'b1; start8 = 1'b1;
    q8.push_back('{res: 128'(16'hFFF7), st: cyc + 1});
    q8.push_back('{res: 128'(16'hFFF7), st: cyc + 1 + ITER8 + 1});
    repeat (2 * ITER8 + 1) @(negedge clk);
    start8 = 1'b0;
    wait_drain();

    // asynchronous reset mid-EXEC
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; sm8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_result8", 128'(result8), 128'(0));
    check("async_rst_busy8", 128'(busy8), 128'(0));
    check("async_rst_done8", 128'(done8), 128'(0));
    check("async_rst_result64", result64, 128'(0));
    q8.delete();
    @(negedge clk);
    reset_n = 1'b1;

    op8(8'h0C, 8'h0D, 1'b0, 16'h009C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
